h_and16_arb: RTL and testbench

H_AND16_ARB -- requirements
Module: h_and16_arb

---
 rtl/h_and16_arb.sv | 147 ++++++++++++++
 tb/tb_h_and16_arb.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/h_and16_arb.sv
// h_and16_arb: two requesters share one 16-bit AND unit.
// Round-robin arbitration, one op in flight, IDLE/EXEC/RESP FSM.

module h_and16_unit (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic [15:0] y_o
);

    assign y_o = a_i & b_i;

endmodule

module h_and16_arb #(
    parameter int PRIO_INIT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    output logic        req1_ready,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        rsp_id,
    input  logic        rsp_ready,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic PTR_RST = (PRIO_INIT != 0);

    state_t      state_q, state_d;
    logic        ptr_q, ptr_d;
    logic [15:0] op_a_q, op_a_d;
    logic [15:0] op_b_q, op_b_d;
    logic        op_id_q, op_id_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [15:0] rsp_data_q, rsp_data_d;
    logic        rsp_id_q, rsp_id_d;

    logic        grant0, grant1;
    logic        acc0, acc1;
    logic [15:0] and_y;

    // the one shared AND unit, fed only from the operand registers
    h_and16_unit u_and (
        .a_i (op_a_q),
        .b_i (op_b_q),
        .y_o (and_y)
    );

    // a lone requester wins outright; a tie goes to ptr
    always_comb begin
        grant0 = req0_valid & (~req1_valid | ~ptr_q);
        grant1 = req1_valid & (~req0_valid | ptr_q);
    end

    // readys only offered in IDLE and never while reset is held
    assign req0_ready = rst_n & (state_q == IDLE) & grant0;
    assign req1_ready = rst_n & (state_q == IDLE) & grant1;

    assign acc0 = req0_valid & req0_ready;
    assign acc1 = req1_valid & req1_ready;

    // next-state: capture on accept, compute in EXEC, hold in RESP
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_id_d     = op_id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        unique case (state_q)
            IDLE: begin
                if (acc0) begin
                    op_a_d  = req0_a;
                    op_b_d  = req0_b;
                    op_id_d = 1'b0;
                    state_d = EXEC;
                end else if (acc1) begin
                    op_a_d  = req1_a;
                    op_b_d  = req1_b;
                    op_id_d = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                rsp_data_d  = and_y;
                rsp_id_d    = op_id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    ptr_d       = ~rsp_id_q;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // state registers; reset drops any in-flight transaction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= PTR_RST;
            op_a_q      <= 16'h0000;
            op_b_q      <= 16'h0000;
            op_id_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 16'h0000;
            rsp_id_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_id_q     <= op_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_h_and16_arb.sv
// tb_h_and16_arb: directed scenarios plus random traffic,
// checked each cycle against a transaction-level model.

module tb_h_and16_arb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0;
    logic [15:0] req0_a = '0;
    logic [15:0] req0_b = '0;
    logic        req0_ready;
    logic        req1_valid = 1'b0;
    logic [15:0] req1_a = '0;
    logic [15:0] req1_b = '0;
    logic        req1_ready;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_id;
    logic        rsp_ready = 1'b0;
    logic        busy;

    int total = 0;
    int bad = 0;

    h_and16_arb #(.PRIO_INIT(0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .rsp_ready  (rsp_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Transaction model: one op in flight; its result becomes visible
    // one edge after the accepting edge and stays until taken.
    bit          m_inflight = 1'b0;
    int          m_edges = 0;
    bit          m_ptr = 1'b0;
    logic [15:0] m_a = '0;
    logic [15:0] m_b = '0;
    bit          m_id = 1'b0;
    bit          e0, e1, ev;

    // per-cycle compare against the model, then advance the model
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_data", rsp_data, 0);
            chk("rst_rsp_id", rsp_id, 0);
            chk("rst_busy", busy, 0);
            chk("rst_ready0", req0_ready, 0);
            chk("rst_ready1", req1_ready, 0);
            m_inflight = 1'b0;
            m_edges = 0;
            m_ptr = 1'b0;
        end else begin
            e0 = !m_inflight && req0_valid && (!req1_valid || m_ptr == 1'b0);
            e1 = !m_inflight && req1_valid && (!req0_valid || m_ptr == 1'b1);
            ev = m_inflight && m_edges >= 1;
            chk("ready0", req0_ready, e0);
            chk("ready1", req1_ready, e1);
            chk("both_ready", req0_ready & req1_ready, 0);
            chk("busy", busy, m_inflight);
            chk("rsp_valid", rsp_valid, ev);
            if (ev) begin
                chk("rsp_data", rsp_data, m_a & m_b);
                chk("rsp_id", rsp_id, m_id);
            end
            if (m_inflight) begin
                if (ev && rsp_ready) begin
                    m_inflight = 1'b0;
                    m_ptr = !m_id;
                end else begin
                    m_edges++;
                end
            end else if (e0) begin
                m_inflight = 1'b1;
                m_edges = 0;
                m_a = req0_a;
                m_b = req0_b;
                m_id = 1'b0;
            end else if (e1) begin
                m_inflight = 1'b1;
                m_edges = 0;
                m_a = req1_a;
                m_b = req1_b;
                m_id = 1'b1;
            end
        end
    end

    logic [15:0] got_d [4];
    logic        got_id [4];
    int          n;
    bit          ok;
    int          acc_c [$];
    logic [15:0] hold_d;
    logic        hold_id;

    initial begin
        // reset held with a request pending: no ready may show
        req0_valid = 1'b1;
        tick;
        tick;
        chk("lit_rst_ready0", req0_ready, 0);
        chk("lit_rst_busy", busy, 0);

        // single request, ready in the same cycle reset releases
        rsp_ready = 1'b1;
        req0_a = 16'hFFFF;
        req0_b = 16'h0F0F;
        rst_n = 1'b1;
        #1;
        chk("lit_single_ready", req0_ready, 1);
        tick;
        req0_valid = 1'b0;
        chk("lit_single_exec_busy", busy, 1);
        chk("lit_single_exec_v", rsp_valid, 0);
        tick;
        chk("lit_single_v", rsp_valid, 1);
        chk("lit_single_data", rsp_data, 16'h0F0F);
        chk("lit_single_id", rsp_id, 0);
        tick;
        chk("lit_single_idle", busy, 0);

        // contention from reset: alternating grants
        rst_n = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        req0_valid = 1'b1;
        req0_a = 16'hAAAA;
        req0_b = 16'hFFFF;
        req1_valid = 1'b1;
        req1_a = 16'h1234;
        req1_b = 16'h00FF;
        n = 0;
        for (int c = 0; c < 20 && n < 4; c++) begin
            if (rsp_valid && rsp_ready) begin
                got_d[n] = rsp_data;
                got_id[n] = rsp_id;
                n++;
            end
            tick;
        end
        chk("lit_cont_count", n, 4);
        chk("lit_cont_d0", got_d[0], 16'hAAAA);
        chk("lit_cont_i0", got_id[0], 0);
        chk("lit_cont_d1", got_d[1], 16'h0034);
        chk("lit_cont_i1", got_id[1], 1);
        chk("lit_cont_d2", got_d[2], 16'hAAAA);
        chk("lit_cont_i2", got_id[2], 0);
        chk("lit_cont_d3", got_d[3], 16'h0034);
        chk("lit_cont_i3", got_id[3], 1);

        // backpressure: response held for 5 cycles
        req1_valid = 1'b0;
        req0_valid = 1'b1;
        req0_a = 16'h5A5A;
        req0_b = 16'h0FF0;
        rsp_ready = 1'b0;
        #1;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
            tick;
        end
        chk("lit_bp_wait", ok, 1);
        req1_valid = 1'b1;
        hold_d = rsp_data;
        hold_id = rsp_id;
        chk("lit_bp_data", hold_d, 16'h0A50);
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("lit_bp_hold_d", rsp_data, hold_d);
            chk("lit_bp_hold_id", rsp_id, hold_id);
            chk("lit_bp_busy", busy, 1);
            chk("lit_bp_rdy0", req0_ready, 0);
            chk("lit_bp_rdy1", req1_ready, 0);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b1;
        tick;
        chk("lit_bp_idle", busy, 0);
        chk("lit_bp_v_clr", rsp_valid, 0);

        // reset while in EXEC discards the transaction
        req1_valid = 1'b1;
        req1_a = 16'hFFFF;
        req1_b = 16'h1111;
        #1;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (req1_ready) begin
                ok = 1'b1;
                break;
            end
            tick;
        end
        chk("lit_rx_wait", ok, 1);
        tick;
        chk("lit_rx_exec", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("lit_rx_v", rsp_valid, 0);
        chk("lit_rx_d", rsp_data, 0);
        chk("lit_rx_id", rsp_id, 0);
        chk("lit_rx_busy", busy, 0);
        chk("lit_rx_rdy1", req1_ready, 0);
        tick;
        req1_valid = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("lit_rx_no_rsp", rsp_valid, 0);
        end

        // back-to-back on requester 1
        req1_valid = 1'b1;
        req1_a = 16'hC3C3;
        req1_b = 16'hFF00;
        rsp_ready = 1'b1;
        #1;
        for (int c = 0; c < 20; c++) begin
            if (req1_ready) acc_c.push_back(c);
            tick;
        end
        chk("lit_b2b_count", acc_c.size() >= 6, 1);
        for (int i = 1; i < acc_c.size(); i++)
            chk("lit_b2b_gap", acc_c[i] - acc_c[i-1], 3);
        req1_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick;

        // operand isolation after accept
        req0_valid = 1'b1;
        req0_a = 16'hF00F;
        req0_b = 16'hFFFF;
        #1;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (req0_ready) begin
                ok = 1'b1;
                break;
            end
            tick;
        end
        chk("lit_iso_wait", ok, 1);
        tick;
        req0_a = 16'h0000;
        req0_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
            tick;
        end
        chk("lit_iso_rsp", ok, 1);
        chk("lit_iso_data", rsp_data, 16'hF00F);
        tick;

        // random traffic with occasional reset pulses
        for (int c = 0; c < 1500; c++) begin
            req0_valid = ($urandom_range(99) < 55);
            req1_valid = ($urandom_range(99) < 55);
            req0_a = 16'($urandom);
            req0_b = 16'($urandom);
            req1_a = 16'($urandom);
            req1_b = 16'($urandom);
            rsp_ready = ($urandom_range(99) < 70);
            if (rst_n && $urandom_range(99) == 0) rst_n = 1'b0;
            else rst_n = 1'b1;
            tick;
        end

        rst_n = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
